serial_addsub: RTL and testbench

Parametrised digit-serial adder/subtractor. It processes DIGIT bits per clock over WIDTH-bit operands under a three-state control FSM, with valid/ready handshakes on the command and result sides. It produces the sum or difference plus carry-out and signed-overflow flags. The block sits beside the existing serial arithmetic blocks as a width-, digit- and mode-generalised successor for area-constrained datapaths.

---
 rtl/serial_addsub.sv | 109 ++++++++++
 tb/tb_serial_addsub.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle over WIDTH-bit operands,
// with valid/ready handshakes on command and result sides.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);
  localparam int NSTEPS = WIDTH / DIGIT;
  localparam int CW     = $clog2(NSTEPS) + 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_out;
  logic             r_carry, r_a_msb, r_b_msb, r_cout, r_ovf;
  logic [CW-1:0]    r_count;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_last;

  assign w_sum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_last = (r_count == CW'(NSTEPS - 1));

  // New digit enters at the MSB end so the result lands LSB-aligned after NSTEPS shifts.
  if (DIGIT == WIDTH) begin : g_one_step
    assign w_out_nxt = w_sum[DIGIT-1:0];
  end else begin : g_multi_step
    assign w_out_nxt = {w_sum[DIGIT-1:0], r_out[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (done_ready)  w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_valid) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub;
          r_count <= '0;
          r_out   <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
          r_a_msb <= a[WIDTH-1];
          r_b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end
        S_RUN: begin
          r_out   <= w_out_nxt;
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_sum[DIGIT];
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_cout <= w_sum[DIGIT];
            r_ovf  <= (r_a_msb == r_b_msb) && (w_sum[DIGIT-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign out         = r_out;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and back-to-back checks of serial_addsub at four WIDTH/DIGIT points,
// each instance driven on its own handshake lines with shared operand buses.
module tb_serial_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sv, dr, sr, dv, bz, co, ov;
  logic [31:0] ta, tbv;
  logic        tsub;
  logic [7:0]  out0, out1;
  logic [15:0] out2;
  logic [31:0] out3;
  logic [31:0] ro [4];

  assign ro[0] = {24'b0, out0};
  assign ro[1] = {24'b0, out1};
  assign ro[2] = {16'b0, out2};
  assign ro[3] = out3;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
    .a(ta[7:0]), .b(tbv[7:0]), .sub(tsub), .out(out0), .cout(co[0]), .ovf(ov[0]),
    .done_valid(dv[0]), .done_ready(dr[0]), .busy(bz[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(2)) u1 (.clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
    .a(ta[7:0]), .b(tbv[7:0]), .sub(tsub), .out(out1), .cout(co[1]), .ovf(ov[1]),
    .done_valid(dv[1]), .done_ready(dr[1]), .busy(bz[1]));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(sr[2]),
    .a(ta[15:0]), .b(tbv[15:0]), .sub(tsub), .out(out2), .cout(co[2]), .ovf(ov[2]),
    .done_valid(dv[2]), .done_ready(dr[2]), .busy(bz[2]));
  serial_addsub #(.WIDTH(32), .DIGIT(8)) u3 (.clk(clk), .rst(rst), .start_valid(sv[3]), .start_ready(sr[3]),
    .a(ta), .b(tbv), .sub(tsub), .out(out3), .cout(co[3]), .ovf(ov[3]),
    .done_valid(dv[3]), .done_ready(dr[3]), .busy(bz[3]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int NS [4] = '{8, 4, 4, 4};
  int WD [4] = '{8, 8, 16, 32};

  typedef struct {
    int          idx;
    logic [31:0] a, b;
    logic        s;
    logic [31:0] eo;
    logic        ec, ev;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-word modulo arithmetic, independent of digit stepping.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [32:0] am, bm, sm;
    logic [31:0] mask, o;
    logic        c, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = {1'b0, a & mask};
    bm   = {1'b0, (s ? ~b : b) & mask};
    sm   = am + bm + {32'b0, s};
    o    = sm[31:0] & mask;
    c    = sm[w];
    v    = (am[w-1] == bm[w-1]) && (o[w-1] != am[w-1]);
    return {c, v, o};
  endfunction

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] o, output logic c, output logic v);
    int lat;
    logic seen;
    @(negedge clk);
    ta = a; tbv = b; tsub = s; sv[i] = 1'b1;
    @(posedge clk); #1;
    sv[i] = 1'b0; ta = $urandom; tbv = $urandom; tsub = ~s;
    chk("busy_after_accept", {31'b0, bz[i]}, 1);
    lat  = 0;
    seen = dv[i];
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      seen = dv[i];
    end
    chk("latency", lat, NS[i]);
    o = ro[i]; c = co[i]; v = ov[i];
    chk("done_flags", {29'b0, bz[i], sr[i], dv[i]}, 32'b101);
    dr[i] = 1'b1;
    @(posedge clk); #1;
    dr[i] = 1'b0;
    chk("idle_after_done", {29'b0, bz[i], sr[i], dv[i]}, 32'b010);
  endtask

  initial begin
    logic [31:0] o;
    logic        c, v;
    logic [33:0] e;
    logic [33:0] q [$];
    int          cyc, acc_prev, got;

    vt[0] = '{0, 32'h5A,       32'h3C,       1'b0, 32'h96,  1'b0, 1'b1};
    vt[1] = '{0, 32'h10,       32'h20,       1'b1, 32'hF0,  1'b0, 1'b0};
    vt[2] = '{0, 32'h80,       32'h01,       1'b1, 32'h7F,  1'b1, 1'b1};
    vt[3] = '{2, 32'hFFFF,     32'h0001,     1'b0, 32'h0,   1'b1, 1'b0};
    vt[4] = '{2, 32'h1234,     32'h1234,     1'b1, 32'h0,   1'b1, 1'b0};
    vt[5] = '{1, 32'h7F,       32'h01,       1'b0, 32'h80,  1'b0, 1'b1};
    vt[6] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1};
    vt[7] = '{1, 32'h00,       32'h01,       1'b1, 32'hFF,  1'b0, 1'b0};

    sv = '0; dr = '0; ta = '0; tbv = '0; tsub = 1'b0;
    rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("rst_out", ro[i], 0);
      chk("rst_flags", {27'b0, sr[i], dv[i], bz[i], co[i], ov[i]}, 32'b10000);
    end
    #10;
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_op(vt[k].idx, vt[k].a, vt[k].b, vt[k].s, o, c, v);
      chk($sformatf("vec%0d_out", k), o, vt[k].eo);
      chk($sformatf("vec%0d_cout", k), {31'b0, c}, {31'b0, vt[k].ec});
      chk($sformatf("vec%0d_ovf", k), {31'b0, v}, {31'b0, vt[k].ev});
    end

    // Backpressure in DONE with command-side noise.
    @(negedge clk);
    ta = 32'h5A; tbv = 32'h3C; tsub = 1'b0; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    cyc = 0;
    while (!dv[0] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_reach_done", {31'b0, dv[0]}, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sv[0] = ~sv[0]; ta = $urandom; tbv = $urandom; tsub = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_out", ro[0], 32'h96);
      chk("bp_flags", {28'b0, co[0], ov[0], sr[0], dv[0]}, 32'b0101);
    end
    @(negedge clk);
    sv[0] = 1'b0; dr[0] = 1'b1;
    @(posedge clk); #1;
    dr[0] = 1'b0;
    chk("bp_release", {29'b0, bz[0], sr[0], dv[0]}, 32'b010);
    chk("bp_out_held_idle", ro[0], 32'h96);

    // Asynchronous reset three cycles into a run.
    @(negedge clk);
    ta = 32'h5A; tbv = 32'h3C; tsub = 1'b0; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_out", ro[0], 0);
    chk("midrun_rst_flags", {27'b0, co[0], ov[0], dv[0], sr[0], bz[0]}, 32'b00010);
    @(negedge clk) rst = 1'b0;
    run_op(0, 32'h01, 32'h01, 1'b0, o, c, v);
    chk("post_rst_add", o, 32'h02);

    // Back-to-back with start_valid and done_ready held high.
    for (int i = 0; i < 4; i++) begin
      q.delete();
      cyc = 0; acc_prev = -1; got = 0;
      sv[i] = 1'b1; dr[i] = 1'b1;
      while (got < 6 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (dv[i]) begin
          if (q.size() == 0) chk("b2b_unexpected_result", 1, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("b2b%0d_out", i), ro[i], e[31:0]);
            chk($sformatf("b2b%0d_cv", i), {30'b0, co[i], ov[i]}, {30'b0, e[33:32]});
          end
          got++;
        end
        ta = $urandom; tbv = $urandom; tsub = 1'($urandom);
        if (sr[i]) begin
          q.push_back(model(WD[i], ta, tbv, tsub));
          if (acc_prev >= 0) chk($sformatf("b2b%0d_spacing", i), cyc - acc_prev, NS[i] + 2);
          acc_prev = cyc;
        end
      end
      sv[i] = 1'b0;
      chk($sformatf("b2b%0d_count", i), got, 6);
      @(posedge clk); #1;
      dr[i] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
